gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk: RTL and testbench
========================================================

GF180MCU_FD_SC_MCU7T5V0__NOR3_ARC_CHK -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk

Interface
REQ-001 Parameter SETTLE, default 2: number of cycles a vector is held on A1..A3 before ZN is sampled; legal range is 1..15.
REQ-002 CLK  input  1  Single clock; all state updates on its rising edge.
REQ-003 RN  input  1  Reset, synchronous and active-low, sampled on rising CLK.
REQ-004 START  input  1  Request to run one check pass; sampled only in IDLE.
REQ-005 A1, A2, A3  output  1 each  Stimulus driven into the NOR3 cell under test.
REQ-006 ZN  input  1  Output of the NOR3 cell under test.
REQ-007 BUSY  output  1  High while a pass is in progress.
REQ-008 DONE  output  1  High from pass completion until the next accepted START or reset.
REQ-009 PASS  output  1  Valid while DONE is high: 1 when ERRCNT equals 0.
REQ-010 ERRCNT  output  8  Count of mismatches in the current or last pass; saturates at 255.
REQ-011 FAIL_VEC  output  3  {A3,A2,A1} of the first mismatching step; 3'b000 when there is none.
REQ-012 VDD, VSS  inout  1 each  Supply pins, passed through only; they carry no logic.

Function
REQ-013 The block steps through 9 vectors {A3,A2,A1}: 000, 001, 011, 010, 110, 111, 101, 100, 000.
- Gray order: every step toggles exactly one input.
- Each arc A1/A2/A3->ZN is exercised in both rise and fall directions.
REQ-014 FSM states:
- IDLE: START=1 -> DRIVE, step=0.
- DRIVE: holds the vector for SETTLE cycles, then -> CHECK.
- CHECK: one cycle; compares ZN; step<8 -> DRIVE with step+1; step=8 -> FIN.
- FIN: one cycle; asserts DONE; -> IDLE.
REQ-015 Expected ZN is ~(A1|A2|A3) of the current vector. A ZN value of X or Z counts as a mismatch.
REQ-016 On a mismatch in CHECK:
- ERRCNT increments, saturating at 255.
- FAIL_VEC is loaded only when ERRCNT was 0 before the increment.
REQ-017 Accepting START has these effects:
- clears ERRCNT, FAIL_VEC and DONE;
- sets BUSY;
- drives vector step 0 on the next cycle.
REQ-018 Latency: each step takes SETTLE+1 cycles. DONE rises 9*(SETTLE+1)+1 rising edges after the edge that samples START (28 edges for SETTLE=2). BUSY falls on that same edge.
REQ-019 START while BUSY is ignored. START held high in IDLE starts a new pass immediately after FIN.
REQ-020 A1..A3 are registered outputs, glitch-free, changing only on rising CLK. In IDLE they hold 000.
REQ-021 ERRCNT, FAIL_VEC and PASS hold their values after DONE until the next accepted START.

Reset
REQ-022 While RN=0 at a rising CLK, all of the following apply on that edge:
- state becomes IDLE;
- A1..A3=0, BUSY=0, DONE=0, PASS=0, ERRCNT=0, FAIL_VEC=0;
- the step and settle counters clear.
REQ-023 Reset asserted mid-pass aborts the pass. DONE is not raised and no partial result is retained.
REQ-024 START sampled in the same cycle as RN=0 is discarded.

Structure
REQ-025 The shared package gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg holds:
- the FSM state enum;
- the 9-entry vector table;
- NSTEP=9;
- the SETTLE width constant.
REQ-026 A single sub-module, gf180mcu_fd_sc_mcu7t5v0__nor3_chk_vecgen, maps the step index to the vector and the expected ZN. It is purely combinational, table-driven from the package.

Verification
REQ-027 Ideal NOR3 model on ZN, SETTLE=2, one START pulse -> DONE at edge 28, PASS=1, ERRCNT=0, FAIL_VEC=000, and the A-pin sequence exactly as in REQ-013.
REQ-028 ZN stuck at 0 -> mismatches at steps 0 and 8 -> ERRCNT=2, FAIL_VEC=000, PASS=0.
REQ-029 ZN stuck at 1 -> 7 mismatches -> ERRCNT=7, FAIL_VEC=001, PASS=0.
REQ-030 RN driven low during step 4 -> outputs return to reset values on the next edge, DONE stays 0; a fresh START then completes a normal 28-edge pass.
REQ-031 START pulsed at steps 2 and 6 of a running pass -> no restart, and DONE timing is unchanged.
REQ-032 SETTLE=1 with ZN driven X for one cycle at step 3 -> ERRCNT=1, FAIL_VEC=010, DONE at edge 19.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg.sv
// Shared definitions for the NOR3 arc checker: FSM states, the Gray-ordered
// stimulus table and the counter widths used by the sequencer.
package gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg;

   localparam int NSTEP    = 9;
   localparam int STEP_W   = 4;
   localparam int SETTLE_W = 4;

   localparam logic [STEP_W-1:0] LAST_STEP = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_FIN   = 2'd3
   } chk_state_e;

   // {A3,A2,A1} per step; index 0 is the rightmost entry. Adjacent entries
   // differ in exactly one bit so every arc sees a clean single-input edge.
   localparam logic [NSTEP-1:0][2:0] VEC_TABLE = {
      3'b000, 3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
   };

   // Ideal NOR3 response for a given {A3,A2,A1} vector.
   function automatic logic nor3_exp(input logic [2:0] vec);
      return ~(vec[0] | vec[1] | vec[2]);
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_chk_vecgen.sv
// Combinational step-index to stimulus-vector / expected-ZN lookup.
module gf180mcu_fd_sc_mcu7t5v0__nor3_chk_vecgen
   import gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg::*;
(
   input  logic [STEP_W-1:0] step,
   output logic [2:0]        vec,
   output logic              exp_zn
);

   // Table lookup; indices beyond the last step fall back to the idle vector.
   always_comb begin
      vec = 3'b000;
      if (step <= LAST_STEP) begin
         vec = VEC_TABLE[step];
      end else begin
         vec = 3'b000;
      end
   end

   assign exp_zn = nor3_exp(vec);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk.sv
// NOR3 arc checker: walks the cell inputs through a Gray sequence, lets each
// vector settle, compares ZN against the ideal NOR3 and reports the result.
module gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk
   import gf180mcu_fd_sc_mcu7t5v0__nor3_chk_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic       CLK,
   input  logic       RN,
   input  logic       START,
   input  logic       ZN,
   output logic       A1,
   output logic       A2,
   output logic       A3,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] ERRCNT,
   output logic [2:0] FAIL_VEC,
   inout  wire        VDD,
   inout  wire        VSS
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

   chk_state_e          state_r, state_nxt_s;
   logic [STEP_W-1:0]   step_r, step_nxt_s;
   logic [SETTLE_W-1:0] cnt_r, cnt_nxt_s;
   logic [2:0]          a_r, a_nxt_s;
   logic                exp_r, exp_nxt_s;
   logic                busy_r, busy_nxt_s;
   logic                done_r, done_nxt_s;
   logic                pass_r, pass_nxt_s;
   logic [7:0]          errcnt_r, errcnt_nxt_s;
   logic [2:0]          fail_vec_r, fail_vec_nxt_s;
   logic [2:0]          vec_nxt_s;
   logic                vec_exp_s;
   logic                mismatch_s;

   // Supplies are pass-through only; this just marks them as intentionally unread.
   wire supply_unused_s;
   assign supply_unused_s = VDD ^ VSS;

   gf180mcu_fd_sc_mcu7t5v0__nor3_chk_vecgen u_vecgen (
      .step   (step_nxt_s),
      .vec    (vec_nxt_s),
      .exp_zn (vec_exp_s)
   );

   // Sequencer state, step index and settle counter.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         state_r <= ST_IDLE;
         step_r  <= 4'd0;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         step_r  <= step_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic: IDLE -> (DRIVE x SETTLE, CHECK) x 9 -> FIN -> IDLE.
   always_comb begin
      state_nxt_s = state_r;
      step_nxt_s  = step_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt_s = ST_DRIVE;
               step_nxt_s  = 4'd0;
               cnt_nxt_s   = 4'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_r == SETTLE_LAST) begin
               state_nxt_s = ST_CHECK;
               cnt_nxt_s   = 4'd0;
            end else begin
               cnt_nxt_s   = cnt_r + 4'd1;
            end
         end
         ST_CHECK: begin
            if (step_r == LAST_STEP) begin
               state_nxt_s = ST_FIN;
            end else begin
               state_nxt_s = ST_DRIVE;
               step_nxt_s  = step_r + 4'd1;
               cnt_nxt_s   = 4'd0;
            end
         end
         ST_FIN: begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = 4'd0;
            cnt_nxt_s   = 4'd0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = 4'd0;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // Compare ZN in CHECK; an X/Z ZN fails the equality and lands in the else branch.
   always_comb begin
      mismatch_s = 1'b0;
      if (state_r == ST_CHECK) begin
         if (ZN == exp_r) begin
            mismatch_s = 1'b0;
         end else begin
            mismatch_s = 1'b1;
         end
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Next values of the registered outputs and the stimulus pins.
   always_comb begin
      busy_nxt_s     = busy_r;
      done_nxt_s     = done_r;
      pass_nxt_s     = pass_r;
      errcnt_nxt_s   = errcnt_r;
      fail_vec_nxt_s = fail_vec_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               busy_nxt_s     = 1'b1;
               done_nxt_s     = 1'b0;
               pass_nxt_s     = 1'b0;
               errcnt_nxt_s   = 8'd0;
               fail_vec_nxt_s = 3'b000;
            end else begin
               busy_nxt_s     = 1'b0;
            end
         end
         ST_CHECK: begin
            if (mismatch_s) begin
               if (errcnt_r != 8'hFF) begin
                  errcnt_nxt_s = errcnt_r + 8'd1;
               end else begin
                  errcnt_nxt_s = errcnt_r;
               end
               if (errcnt_r == 8'd0) begin
                  fail_vec_nxt_s = a_r;
               end else begin
                  fail_vec_nxt_s = fail_vec_r;
               end
            end else begin
               errcnt_nxt_s = errcnt_r;
            end
         end
         ST_FIN: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b1;
            pass_nxt_s = (errcnt_r == 8'd0);
         end
         ST_DRIVE: begin
            busy_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
      if ((state_nxt_s == ST_DRIVE) || (state_nxt_s == ST_CHECK)) begin
         a_nxt_s   = vec_nxt_s;
         exp_nxt_s = vec_exp_s;
      end else begin
         a_nxt_s   = 3'b000;
         exp_nxt_s = 1'b1;
      end
   end

   // Output and stimulus registers.
   always_ff @(posedge CLK) begin
      if (!RN) begin
         a_r        <= 3'b000;
         exp_r      <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         errcnt_r   <= 8'd0;
         fail_vec_r <= 3'b000;
      end else begin
         a_r        <= a_nxt_s;
         exp_r      <= exp_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         pass_r     <= pass_nxt_s;
         errcnt_r   <= errcnt_nxt_s;
         fail_vec_r <= fail_vec_nxt_s;
      end
   end

   assign A1       = a_r[0];
   assign A2       = a_r[1];
   assign A3       = a_r[2];
   assign BUSY     = busy_r;
   assign DONE     = done_r;
   assign PASS     = pass_r;
   assign ERRCNT   = errcnt_r;
   assign FAIL_VEC = fail_vec_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk.sv
// Scoreboard bench for the NOR3 arc checker: two instances (SETTLE=2 and
// SETTLE=1) drive behavioural NOR3 models with selectable faults.
module tb_gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rn2, rn1, start2, start1, zn2, zn1;
   logic a1_2, a2_2, a3_2, busy2, done2, pass2;
   logic a1_1, a2_1, a3_1, busy1, done1, pass1;
   logic [7:0] err2, err1;
   logic [2:0] fv2, fv1;
   wire vdd = 1'b1;
   wire vss = 1'b0;

   int mode2 = 0;   // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
   int mode1 = 0;   // 0 ideal, 3 corrupt ZN while A=010
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   typedef struct { int at; logic pass; logic [7:0] err; logic [2:0] fv; } res_t;
   typedef struct { int at; logic [2:0] vec; } vec_t;
   res_t rq2[$];
   res_t rq1[$];
   vec_t vq2[$];

   logic [2:0] gray_tbl [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                3'b111, 3'b101, 3'b100, 3'b000};

   assign zn2 = (mode2 == 1) ? 1'b0 : (mode2 == 2) ? 1'b1 : ~(a1_2 | a2_2 | a3_2);
   assign zn1 = ((mode1 == 3) && ({a3_1, a2_1, a1_1} == 3'b010)) ? 1'b1
              : ~(a1_1 | a2_1 | a3_1);

   gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk #(.SETTLE(2)) u2 (
      .CLK(clk), .RN(rn2), .START(start2), .ZN(zn2),
      .A1(a1_2), .A2(a2_2), .A3(a3_2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
      .ERRCNT(err2), .FAIL_VEC(fv2), .VDD(vdd), .VSS(vss)
   );

   gf180mcu_fd_sc_mcu7t5v0__nor3_arc_chk #(.SETTLE(1)) u1 (
      .CLK(clk), .RN(rn1), .START(start1), .ZN(zn1),
      .A1(a1_1), .A2(a2_1), .A3(a3_1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
      .ERRCNT(err1), .FAIL_VEC(fv1), .VDD(vdd), .VSS(vss)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops expected results on each DONE rise and expected A vectors on their cycle.
   logic done2_q = 1'b0;
   logic done1_q = 1'b0;
   always @(negedge clk) begin : mon
      res_t r;
      vec_t v;
      if (mon_en) begin
         if (done2 && !done2_q) begin
            if (rq2.size() == 0) begin
               flag("u2 unexpected DONE");
            end else begin
               r = rq2.pop_front();
               check("u2 DONE edge", cyc, r.at);
               check("u2 PASS", int'(pass2), int'(r.pass));
               check("u2 ERRCNT", int'(err2), int'(r.err));
               check("u2 FAIL_VEC", int'(fv2), int'(r.fv));
            end
         end
         if (done1 && !done1_q) begin
            if (rq1.size() == 0) begin
               flag("u1 unexpected DONE");
            end else begin
               r = rq1.pop_front();
               check("u1 DONE edge", cyc, r.at);
               check("u1 PASS", int'(pass1), int'(r.pass));
               check("u1 ERRCNT", int'(err1), int'(r.err));
               check("u1 FAIL_VEC", int'(fv1), int'(r.fv));
            end
         end
         while ((vq2.size() > 0) && (vq2[0].at <= cyc)) begin
            v = vq2.pop_front();
            check("u2 A vector", int'({a3_2, a2_2, a1_2}), int'(v.vec));
         end
      end
      done2_q <= done2;
      done1_q <= done1;
   end

   // Issue START on u2 (called at a negedge) and queue what the pass must produce.
   task automatic start_pass2(input logic p, input logic [7:0] e, input logic [2:0] f,
                              input bit push_res, input bit push_vec, output int s);
      s = cyc + 1;
      if (push_res) rq2.push_back('{at: s + 28, pass: p, err: e, fv: f});
      if (push_vec) begin
         for (int k = 0; k < 9; k++) vq2.push_back('{at: s + 3 * k, vec: gray_tbl[k]});
      end
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic wait_drained(input string name, input int limit);
      int n;
      n = 0;
      while (((rq2.size() + rq1.size() + vq2.size()) != 0) && (n < limit)) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= limit) begin
         fails++;
         $display("FAIL %s: timeout after %0d cycles, %0d items outstanding", name, n,
                  rq2.size() + rq1.size() + vq2.size());
      end
   endtask

   task automatic check_reset2(input string tag);
      check({tag, " BUSY"}, int'(busy2), 0);
      check({tag, " DONE"}, int'(done2), 0);
      check({tag, " PASS"}, int'(pass2), 0);
      check({tag, " ERRCNT"}, int'(err2), 0);
      check({tag, " FAIL_VEC"}, int'(fv2), 0);
      check({tag, " A"}, int'({a3_2, a2_2, a1_2}), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int s;
      rn2 = 1'b0; rn1 = 1'b0;
      start2 = 1'b1; start1 = 1'b1;      // START during reset must be discarded
      repeat (3) @(negedge clk);
      start2 = 1'b0; start1 = 1'b0;
      rn2 = 1'b1; rn1 = 1'b1;
      mon_en = 1'b1;
      check_reset2("reset");
      check("reset u1 BUSY", int'(busy1), 0);
      check("reset u1 ERRCNT", int'(err1), 0);
      @(negedge clk);
      check("idle after reset BUSY", int'(busy2), 0);

      // Ideal cell: full Gray sequence and a clean pass.
      mode2 = 0;
      start_pass2(1'b1, 8'd0, 3'b000, 1'b1, 1'b1, s);
      check("ideal BUSY mid-pass", int'(busy2), 1);
      wait_drained("ideal pass", 60);
      repeat (3) @(negedge clk);
      check("hold DONE", int'(done2), 1);
      check("hold PASS", int'(pass2), 1);
      check("hold BUSY low", int'(busy2), 0);

      // Stuck-at-0 and stuck-at-1 outputs.
      mode2 = 1;
      start_pass2(1'b0, 8'd2, 3'b000, 1'b1, 1'b0, s);
      wait_drained("stuck0 pass", 60);
      mode2 = 2;
      start_pass2(1'b0, 8'd7, 3'b001, 1'b1, 1'b0, s);
      wait_drained("stuck1 pass", 60);
      check("idle A after pass", int'({a3_2, a2_2, a1_2}), 0);

      // START pulses during steps 2 and 6 must not restart the pass.
      mode2 = 0;
      start_pass2(1'b1, 8'd0, 3'b000, 1'b1, 1'b0, s);
      while (cyc < s + 7) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      while (cyc < s + 19) @(negedge clk);
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      check("ignored START BUSY", int'(busy2), 1);
      wait_drained("START-while-busy pass", 60);

      // Reset during step 4 aborts the pass; a fresh START then runs normally.
      mode2 = 2;
      start_pass2(1'b0, 8'd0, 3'b000, 1'b0, 1'b0, s);
      while (cyc < s + 13) @(negedge clk);
      check("pre-abort ERRCNT", int'(err2), 3);
      check("pre-abort A step4", int'({a3_2, a2_2, a1_2}), 6);
      rn2 = 1'b0;
      @(negedge clk);
      rn2 = 1'b1;
      check_reset2("abort");
      repeat (35) @(negedge clk);
      check("abort no DONE", int'(done2), 0);
      mode2 = 0;
      start_pass2(1'b1, 8'd0, 3'b000, 1'b1, 1'b1, s);
      wait_drained("post-abort pass", 60);

      // START held high: a second pass begins right after FIN.
      s = cyc + 1;
      rq2.push_back('{at: s + 28, pass: 1'b1, err: 8'd0, fv: 3'b000});
      rq2.push_back('{at: s + 57, pass: 1'b1, err: 8'd0, fv: 3'b000});
      start2 = 1'b1;
      while (cyc < s + 29) @(negedge clk);
      start2 = 1'b0;
      check("back-to-back BUSY", int'(busy2), 1);
      wait_drained("held START passes", 80);

      // SETTLE=1 instance, ZN corrupted during step 3.
      mode1 = 3;
      s = cyc + 1;
      rq1.push_back('{at: s + 19, pass: 1'b0, err: 8'd1, fv: 3'b010});
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_drained("settle1 pass", 40);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
